// File: rtl/prog_delay_line.sv
// rtl/prog_delay_line.sv - programmable sample-count delay line over a circular buffer
module prog_delay_line #(
  parameter int DATA_W     = 64,
  parameter int MAX_DELAY  = 32,
  parameter int INIT_DELAY = 1,
  localparam int DW        = $clog2(MAX_DELAY + 1),
  localparam int AW        = $clog2(MAX_DELAY)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic        [DW-1:0]     delay_sel,
  input  logic                     delay_load,
  input  logic                     flush,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     primed,
  output logic        [DW-1:0]     cur_delay
);

  localparam logic [DW-1:0] MAX_D   = DW'(MAX_DELAY);
  localparam logic [DW-1:0] INIT_D  = DW'(INIT_DELAY);
  localparam logic [DW:0]   DEPTH   = (DW+1)'(MAX_DELAY);
  localparam logic [AW-1:0] LAST_WP = AW'(MAX_DELAY - 1);

  logic signed [DATA_W-1:0] r_mem [MAX_DELAY];
  logic        [AW-1:0]     r_wr_ptr;
  logic        [DW-1:0]     r_d;
  logic        [DW-1:0]     r_fill;
  logic                     r_primed;
  logic                     r_out_valid;
  logic signed [DATA_W-1:0] r_out_data;

  logic                     w_accept;
  logic        [DW-1:0]     w_d_load;
  logic        [DW-1:0]     w_d_eff;
  logic        [DW-1:0]     w_fill_eff;
  logic        [DW-1:0]     w_fill_nxt;
  logic        [DW:0]       w_wr_ext;
  logic        [DW:0]       w_d_ext;
  logic        [DW:0]       w_rd_sum;
  logic        [AW-1:0]     w_rd_idx;
  logic        [AW-1:0]     w_wr_nxt;
  logic signed [DATA_W-1:0] w_out_nxt;

  assign w_accept = in_valid && !flush;
  assign w_d_load = (delay_sel > MAX_D) ? MAX_D : delay_sel;

  // A sample arriving with delay_load already belongs to the new history.
  assign w_d_eff    = delay_load ? w_d_load : r_d;
  assign w_fill_eff = (delay_load || flush) ? '0 : r_fill;

  // Read happens before this cycle's write, so D = MAX_DELAY reads the oldest entry.
  assign w_wr_ext = (DW+1)'(r_wr_ptr);
  assign w_d_ext  = {1'b0, w_d_eff};
  assign w_rd_sum = (w_wr_ext >= w_d_ext) ? (w_wr_ext - w_d_ext)
                                          : (w_wr_ext + DEPTH - w_d_ext);
  assign w_rd_idx = w_rd_sum[AW-1:0];
  assign w_wr_nxt = (r_wr_ptr == LAST_WP) ? '0 : r_wr_ptr + AW'(1);

  always_comb begin
    w_out_nxt = '0;
    if (w_fill_eff >= w_d_eff) begin
      w_out_nxt = (w_d_eff == '0) ? in_data : r_mem[w_rd_idx];
    end
  end

  always_comb begin
    w_fill_nxt = r_fill;
    if (flush) begin
      w_fill_nxt = '0;
    end else if (delay_load) begin
      w_fill_nxt = DW'(in_valid);
    end else if (in_valid && (r_fill != MAX_D)) begin
      w_fill_nxt = r_fill + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_d         <= INIT_D;
      r_fill      <= '0;
      r_primed    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (delay_load) begin
        r_d <= w_d_load;
      end
      r_fill      <= w_fill_nxt;
      r_primed    <= !(delay_load || flush) && (r_fill >= r_d);
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_wr_ptr   <= w_wr_nxt;
        r_out_data <= w_out_nxt;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign primed    = r_primed;
  assign cur_delay = r_d;

endmodule

// File: tb/tb_prog_delay_line.sv
// tb/tb_prog_delay_line.sv - directed self-checking bench for prog_delay_line
module tb_prog_delay_line;

  localparam int DATA_W = 64;
  localparam int MAXD   = 32;
  localparam int DW     = 6;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     in_valid = 1'b0;
  logic signed [DATA_W-1:0] in_data = '0;
  logic        [DW-1:0]     delay_sel = '0;
  logic                     delay_load = 1'b0;
  logic                     flush = 1'b0;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     primed;
  logic        [DW-1:0]     cur_delay;

  int n_tests = 0;
  int n_fail  = 0;

  prog_delay_line #(.DATA_W(DATA_W), .MAX_DELAY(MAXD), .INIT_DELAY(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .delay_sel(delay_sel), .delay_load(delay_load), .flush(flush),
    .out_valid(out_valid), .out_data(out_data), .primed(primed),
    .cur_delay(cur_delay)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, then settle 1 time unit past the edge.
  task automatic send(input logic v, input logic signed [DATA_W-1:0] d,
                      input logic ld, input logic [DW-1:0] sel, input logic fl);
    in_valid = v; in_data = d; delay_load = ld; delay_sel = sel; flush = fl;
    @(posedge clk); #1;
    in_valid = 1'b0; delay_load = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %0d exp 0", out_data); end
    n_tests++; if (primed !== 1'b0) begin n_fail++; $display("FAIL reset_primed got %b exp 0", primed); end
    n_tests++; if (cur_delay !== 6'd1) begin n_fail++; $display("FAIL reset_delay got %0d exp 1", cur_delay); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic signed [DATA_W-1:0] exp;
    send(1'b0, 0, 1'b1, 6'd3, 1'b0);
    n_tests++; if (cur_delay !== 6'd3) begin n_fail++; $display("FAIL basic_delay got %0d exp 3", cur_delay); end
    for (int k = 1; k <= 8; k++) begin
      send(1'b1, k, 1'b0, 6'd0, 1'b0);
      exp = (k <= 3) ? 0 : k - 3;
      n_tests++; if (out_valid !== 1'b1 || out_data !== exp) begin n_fail++; $display("FAIL basic_out k=%0d got %b/%0d exp 1/%0d", k, out_valid, out_data, exp); end
      n_tests++; if (primed !== (k >= 4)) begin n_fail++; $display("FAIL basic_primed k=%0d got %b exp %b", k, primed, (k >= 4)); end
    end
    send(1'b0, 0, 1'b0, 6'd0, 1'b0);
    n_tests++; if (out_valid !== 1'b0 || out_data !== 5) begin n_fail++; $display("FAIL basic_hold got %b/%0d exp 0/5", out_valid, out_data); end
  endtask

  task automatic test_gapped();
    logic signed [DATA_W-1:0] ins [3];
    logic signed [DATA_W-1:0] outs [3];
    ins  = '{10, 20, 30};
    outs = '{0, 0, 10};
    send(1'b0, 0, 1'b1, 6'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send(1'b1, ins[i], 1'b0, 6'd0, 1'b0);
      n_tests++; if (out_valid !== 1'b1 || out_data !== outs[i]) begin n_fail++; $display("FAIL gap_out i=%0d got %b/%0d exp 1/%0d", i, out_valid, out_data, outs[i]); end
      for (int j = 0; j < 2; j++) begin
        send(1'b0, 77, 1'b0, 6'd0, 1'b0);
        n_tests++; if (out_valid !== 1'b0 || out_data !== outs[i]) begin n_fail++; $display("FAIL gap_hold i=%0d got %b/%0d exp 0/%0d", i, out_valid, out_data, outs[i]); end
      end
    end
  endtask

  task automatic test_wrap();
    logic signed [DATA_W-1:0] exp;
    send(1'b0, 0, 1'b1, 6'd32, 1'b0);
    for (int k = 1; k <= 100; k++) begin
      send(1'b1, k, 1'b0, 6'd0, 1'b0);
      exp = (k > 32) ? k - 32 : 0;
      n_tests++; if (out_valid !== 1'b1 || out_data !== exp) begin n_fail++; $display("FAIL wrap_out k=%0d got %b/%0d exp 1/%0d", k, out_valid, out_data, exp); end
    end
  endtask

  task automatic test_runtime_change();
    send(1'b0, 0, 1'b1, 6'd4, 1'b0);
    for (int k = 1; k <= 9; k++) send(1'b1, k, 1'b0, 6'd0, 1'b0);
    n_tests++; if (out_data !== 5) begin n_fail++; $display("FAIL chg_pre got %0d exp 5", out_data); end
    send(1'b1, 10, 1'b1, 6'd1, 1'b0);
    n_tests++; if (out_valid !== 1'b1 || out_data !== 0) begin n_fail++; $display("FAIL chg_load got %b/%0d exp 1/0", out_valid, out_data); end
    n_tests++; if (cur_delay !== 6'd1 || primed !== 1'b0) begin n_fail++; $display("FAIL chg_state got %0d/%b exp 1/0", cur_delay, primed); end
    send(1'b1, 11, 1'b0, 6'd0, 1'b0);
    n_tests++; if (out_data !== 10 || primed !== 1'b1) begin n_fail++; $display("FAIL chg_next got %0d/%b exp 10/1", out_data, primed); end
  endtask

  task automatic test_flush_clamp();
    send(1'b1, 99, 1'b0, 6'd0, 1'b1);
    n_tests++; if (out_valid !== 1'b0 || out_data !== 10 || primed !== 1'b0) begin n_fail++; $display("FAIL flush_drop got %b/%0d/%b exp 0/10/0", out_valid, out_data, primed); end
    send(1'b1, 60, 1'b0, 6'd0, 1'b0);
    n_tests++; if (out_data !== 0) begin n_fail++; $display("FAIL flush_first got %0d exp 0", out_data); end
    send(1'b1, 70, 1'b0, 6'd0, 1'b0);
    n_tests++; if (out_data !== 60) begin n_fail++; $display("FAIL flush_second got %0d exp 60", out_data); end
    send(1'b0, 0, 1'b1, 6'(MAXD + 5), 1'b0);
    n_tests++; if (cur_delay !== 6'(MAXD)) begin n_fail++; $display("FAIL clamp got %0d exp %0d", cur_delay, MAXD); end
    send(1'b1, 99, 1'b1, 6'd2, 1'b1);
    n_tests++; if (out_valid !== 1'b0 || cur_delay !== 6'd2 || primed !== 1'b0) begin n_fail++; $display("FAIL flush_load got %b/%0d/%b exp 0/2/0", out_valid, cur_delay, primed); end
    for (int k = 1; k <= 3; k++) begin
      send(1'b1, k, 1'b0, 6'd0, 1'b0);
      n_tests++; if (out_data !== ((k == 3) ? 1 : 0)) begin n_fail++; $display("FAIL flush_load_out k=%0d got %0d exp %0d", k, out_data, (k == 3) ? 1 : 0); end
    end
  endtask

  task automatic test_zero_delay();
    logic signed [DATA_W-1:0] neg;
    neg = -64'sd5;
    send(1'b1, 7, 1'b1, 6'd0, 1'b0);
    n_tests++; if (out_data !== 7 || cur_delay !== 6'd0) begin n_fail++; $display("FAIL d0_first got %0d/%0d exp 7/0", out_data, cur_delay); end
    send(1'b1, neg, 1'b0, 6'd0, 1'b0);
    n_tests++; if (out_data !== neg || primed !== 1'b1) begin n_fail++; $display("FAIL d0_neg got %0d/%b exp -5/1", out_data, primed); end
  endtask

  task automatic test_async_reset();
    send(1'b0, 0, 1'b1, 6'd2, 1'b0);
    for (int k = 1; k <= 5; k++) send(1'b1, k, 1'b0, 6'd0, 1'b0);
    n_tests++; if (out_data !== 3 || out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre got %b/%0d exp 1/3", out_valid, out_data); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (out_data !== 0 || out_valid !== 1'b0 || primed !== 1'b0 || cur_delay !== 6'd1) begin n_fail++; $display("FAIL arst_now got %b/%0d/%b/%0d exp 0/0/0/1", out_valid, out_data, primed, cur_delay); end
    @(posedge clk); #1 rst = 1'b0;
    send(1'b1, 100, 1'b0, 6'd0, 1'b0);
    n_tests++; if (out_data !== 0) begin n_fail++; $display("FAIL arst_s1 got %0d exp 0", out_data); end
    send(1'b1, 200, 1'b0, 6'd0, 1'b0);
    n_tests++; if (out_data !== 100) begin n_fail++; $display("FAIL arst_s2 got %0d exp 100", out_data); end
    send(1'b1, 300, 1'b0, 6'd0, 1'b0);
    n_tests++; if (out_data !== 200 || cur_delay !== 6'd1) begin n_fail++; $display("FAIL arst_s3 got %0d/%0d exp 200/1", out_data, cur_delay); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_wrap();
    test_runtime_change();
    test_flush_clamp();
    test_zero_delay();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_delay_line.md
PROG_DELAY_LINE -- requirements
Module: prog_delay_line

Interface
REQ-001 Parameter DATA_W, default 64: sample width in bits; samples are signed two's complement.
REQ-002 Parameter MAX_DELAY, default 32: maximum delay in samples; legal range 2..1024.
REQ-003 Parameter INIT_DELAY, default 1: active delay after reset; legal range 0..MAX_DELAY.
REQ-004 Derived width DW = clog2(MAX_DELAY+1).
REQ-005 Port clk, input, 1: clock; all state changes on the rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous, active-high.
REQ-007 Port in_valid, input, 1: in_data holds a new sample this cycle.
REQ-008 Port in_data, input, DATA_W: signed input sample.
REQ-009 Port delay_sel, input, DW: requested delay in samples.
REQ-010 Port delay_load, input, 1: one-cycle strobe that captures delay_sel.
REQ-011 Port flush, input, 1: discards the buffered history.
REQ-012 Port out_valid, output, 1: out_data holds a new delayed sample.
REQ-013 Port out_data, output, DATA_W: signed delayed sample, registered.
REQ-014 Port primed, output, 1: the history holds at least D samples.
REQ-015 Port cur_delay, output, DW: active delay D.

Function
REQ-016 Delay counts accepted samples (in_valid cycles), not clock cycles; idle cycles do not advance the history.
REQ-017 For each accepted sample n, out_valid SHALL pulse exactly one cycle later with out_data = sample n-D when primed, else 0.
REQ-018 For D=0, out_data SHALL equal the same-cycle in_data, registered with one-cycle latency.
REQ-019 Storage: circular buffer of MAX_DELAY entries, write pointer wrapping MAX_DELAY-1 -> 0, read index = (wr_ptr - D) mod MAX_DELAY; wrap SHALL be seamless with no repeated or skipped sample.
REQ-020 fill_cnt counts accepted samples since the last restart and saturates at MAX_DELAY; primed = (fill_cnt >= D), registered.
REQ-021 When out_valid is 0, out_data SHALL hold its previous value.
REQ-022 delay_load captures min(delay_sel, MAX_DELAY) into D; out-of-range values clamp to MAX_DELAY.
REQ-023 Load restarts history: the cycle after delay_load, fill_cnt = 0 and primed = 0. Buffer contents are not cleared but are not output.
REQ-024 If in_valid and delay_load occur in the same cycle, that sample uses the new D and is the first sample of the new history (fill_cnt = 1 next cycle).
REQ-025 flush sets fill_cnt = 0 and primed = 0 the next cycle.
REQ-026 flush takes precedence over in_valid: the sample is dropped and out_valid = 0 next cycle.
REQ-027 flush and delay_load in the same cycle: D is loaded and the history is flushed.
REQ-028 No internal backpressure exists; in_valid may be asserted every cycle.

Reset
REQ-029 While rst is high: out_data = 0, out_valid = 0, primed = 0, fill_cnt = 0, wr_ptr = 0, D = INIT_DELAY.
REQ-030 Buffer memory is not required to reset; it SHALL never reach out_data before being written after the last restart.
REQ-031 rst asserted mid-stream SHALL take effect immediately, regardless of the clock; the first sample after release is treated as history sample 1.

Verification
REQ-032 Basic delay: D=3, in_valid every cycle, samples 1..8 -> out_data sequence 0,0,0,1,2,3,4,5; primed rises with the 4th output.
REQ-033 Gapped input: D=2, samples 10,20,30 with 2 idle cycles between each -> outputs 0,0,10, each one cycle after its input; out_data held between pulses.
REQ-034 Wrap and maximum depth: MAX_DELAY=32, D=32, 100 consecutive samples k=1..100 -> output k is k-32 for k>32 and 0 otherwise; no glitch at pointer wrap.
REQ-035 Runtime delay change: D changed 4->1 at sample 10, sample concurrent with load -> that output is 0, the next output is sample 10; cur_delay = 1.
REQ-036 Flush and clamp: flush with in_valid set drops the sample (out_valid stays 0); delay_sel = MAX_DELAY+5 -> cur_delay = MAX_DELAY.
REQ-037 Async reset mid-stream: rst pulsed between clock edges -> all outputs 0 immediately; after release D = INIT_DELAY and the history restarts from zero.
